result_writeback: RTL and testbench
===================================

Name: result_writeback

Overview:
- Drains the 8 x 24-bit MAC result vector to memory over an Avalon-MM style master write port.
- It is the write-side counterpart of the fetch path that reads operand lines into the A/B FIFOs.
- Snapshots all eight results on start, then issues one write per result to consecutive word addresses from a base address.
- Reports completion with a one-cycle done pulse.

Parameters:
NUM_RES, 8, number of results per vector (index width = $clog2(NUM_RES))
RES_W, 24, width of each MAC result
ADDR_W, 32, memory word-address width
DATA_W, 32, write-data width (must be >= RES_W)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to write back the current results; ignored unless in IDLE
base_addr  input  ADDR_W  word address of result 0, sampled with start
res_in  input  RES_W x NUM_RES (unpacked [RES_W-1:0] [NUM_RES-1:0])  MAC results, sampled with start
avm_address  output  ADDR_W  write word address
avm_write  output  1  write request
avm_writedata  output  DATA_W  write data
avm_waitrequest  input  1  slave stall; transfer completes on a cycle with avm_write=1 and avm_waitrequest=0
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the last transfer completes

Behaviour:
- Reset (asynchronous, any state, mid-transfer included): state=IDLE; avm_write=0, avm_address=0, avm_writedata=0, busy=0, done=0; index=0; snapshot registers=0. An in-flight write is abandoned without a completing handshake.
- State machine: IDLE, WRITE, DONE. Registered outputs only.
- IDLE:
  - start=1: latch res_in[0..NUM_RES-1] into the snapshot; latch base_addr; index=0.
  - Next state WRITE. busy=1 from the next cycle.
- WRITE:
  - avm_write=1, avm_address=base+index, avm_writedata=zero-extend(snapshot[index]) to DATA_W.
  - avm_waitrequest=1: hold avm_write, avm_address and avm_writedata stable.
  - avm_waitrequest=0 with index<NUM_RES-1: index+1, present the next word the following cycle. avm_write stays high, giving back-to-back writes with no bubble.
  - avm_waitrequest=0 with index=NUM_RES-1: avm_write=0 next cycle; go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; return to IDLE.
- Latency with no stalls: start at cycle 0; first write visible at cycle 1; last write at cycle NUM_RES; done at cycle NUM_RES+1. Each stall cycle adds one cycle.
- Address arithmetic: base+index modulo 2^ADDR_W; wraps silently at the top of the address space.
- Boundary cases:
  - start while busy or in DONE is ignored; no queuing.
  - start in the same cycle as done returns to IDLE is ignored.
  - res_in changes after the start cycle have no effect on written data.
  - Sustained waitrequest stalls indefinitely; the block has no timeout.

Optional Feature:
- Macro: RESULT_WB_CHECKSUM_EN.
- Defined: after result NUM_RES-1 completes, one extra write goes to base+NUM_RES. Its data is the zero-extended RES_W-bit modular sum of all snapshot results, with the same handshake rules. done moves one transfer later.
- Undefined: exactly NUM_RES writes; no checksum logic is synthesized.

Decomposition:
- Package result_wb_pkg: state enum (IDLE, WRITE, DONE), NUM_RES/RES_W defaults, and a zero-extend function.
- One natural sub-module: wb_snapshot_regs, holding the NUM_RES x RES_W capture registers with load enable and an indexed read mux.

Test Plan:
- No stalls: base=0x100, results 1..8. Expect writes 0x100..0x107 with data 1..8 on cycles 1..8, done at cycle 9, busy high cycles 1..8.
- Waitrequest high for 3 cycles on the 4th write. Expect address 0x103 and data held stable for 4 cycles, no skipped or duplicated transfers, done at cycle 12.
- Change res_in to 0xFFFFFF on the cycle after start. Expect written data to remain the originally latched values.
- Pulse start during busy and in the done cycle. Expect no restart and no extra writes.
- Assert rst mid-stall on write 5. Expect avm_write=0 and busy=0 immediately. A new start then writes a full 8 words from the new base.
- Wrap and max values: base=0xFFFFFFFE, all results 0xFFFFFF. Expect addresses FFFFFFFE, FFFFFFFF, 0..5 and data 0x00FFFFFF. With RESULT_WB_CHECKSUM_EN, expect a 9th write to address 6 with data 0x00FFFFF8.

Source files
------------

// File: rtl/result_wb_pkg.sv
// Shared types and helpers for the MAC result write-back path.
package result_wb_pkg;
  localparam int NUM_RES_DEF = 8;
  localparam int RES_W_DEF   = 24;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} wb_state_e;

  // Clear every bit above w; callers cast the result down to their bus width.
  function automatic logic [63:0] zext(input logic [63:0] v, input int unsigned w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return v & m;
  endfunction
endpackage

// File: rtl/wb_snapshot_regs.sv
// Capture registers for one result vector, loaded on start, read by index.
module wb_snapshot_regs import result_wb_pkg::*; #(
  parameter int NUM_RES = NUM_RES_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int IDX_W   = (NUM_RES > 1) ? $clog2(NUM_RES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [RES_W-1:0] din [NUM_RES],
  input  logic [IDX_W-1:0] rd_idx,
  output logic [RES_W-1:0] rd_data
);
  logic [RES_W-1:0] snap_q [NUM_RES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_RES; i++) snap_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_RES; i++) snap_q[i] <= din[i];
    end
  end

  // Out-of-range indices read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RES; i++)
      if (rd_idx == IDX_W'(i)) rd_data = snap_q[i];
  end
endmodule

// File: rtl/result_writeback.sv
// Drains a snapshot of NUM_RES MAC results to consecutive word addresses over an
// Avalon-MM write port. RESULT_WB_CHECKSUM_EN appends a modular-sum word.
module result_writeback import result_wb_pkg::*; #(
  parameter int NUM_RES = NUM_RES_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [RES_W-1:0]  res_in [NUM_RES],
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done
);
  localparam int IDX_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_RES - 1);

  wb_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d, busy_q, busy_d, done_q, done_d;
  logic              snap_load;
  logic [IDX_W-1:0]  rd_idx;
  logic [RES_W-1:0]  rd_data;

  function automatic logic [DATA_W-1:0] to_data(input logic [RES_W-1:0] v);
    return DATA_W'(zext(64'(v), RES_W));
  endfunction

  wb_snapshot_regs #(.NUM_RES(NUM_RES), .RES_W(RES_W), .IDX_W(IDX_W)) u_snap (
    .clk(clk), .rst(rst), .load(snap_load), .din(res_in),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

`ifdef RESULT_WB_CHECKSUM_EN
  logic [RES_W-1:0] sum_q, sum_d, sum_in;
  logic             chk_q, chk_d;

  // Summing the inputs at start equals summing the snapshot.
  always_comb begin
    sum_in = '0;
    for (int i = 0; i < NUM_RES; i++) sum_in = sum_in + res_in[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      chk_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      chk_q <= chk_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    snap_load = 1'b0;
    // Prefetch the next word so it is on the bus the cycle after acceptance.
    rd_idx    = idx_q + IDX_W'(1);
`ifdef RESULT_WB_CHECKSUM_EN
    sum_d     = sum_q;
    chk_d     = chk_q;
`endif
    unique case (state_q)
      S_IDLE: if (start) begin
        snap_load = 1'b1;
        base_d    = base_addr;
        idx_d     = '0;
        addr_d    = base_addr;
        wdata_d   = to_data(res_in[0]);
        wr_d      = 1'b1;
        busy_d    = 1'b1;
        state_d   = S_WRITE;
`ifdef RESULT_WB_CHECKSUM_EN
        sum_d     = sum_in;
        chk_d     = 1'b0;
`endif
      end
      S_WRITE: if (!avm_waitrequest) begin
        if (idx_q != LAST) begin
          idx_d   = idx_q + IDX_W'(1);
          addr_d  = base_q + ADDR_W'(idx_q) + ADDR_W'(1);
          wdata_d = to_data(rd_data);
        end
`ifdef RESULT_WB_CHECKSUM_EN
        else if (!chk_q) begin
          chk_d   = 1'b1;
          addr_d  = base_q + ADDR_W'(NUM_RES);
          wdata_d = to_data(sum_q);
        end
`endif
        else begin
          wr_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign avm_address   = addr_q;
  assign avm_write     = wr_q;
  assign avm_writedata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: table vectors, random transactions
// against a transfer-list model, and hand-written reset/stall sequences.
module tb_result_writeback;
  localparam int NR = 8, RW = 24, AW = 32, DW = 32;
`ifdef RESULT_WB_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, wreq;
  logic [AW-1:0] base, addr;
  logic [RW-1:0] res [NR];
  logic [DW-1:0] wdata;
  logic          wr, busy, done;

  int n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  result_writeback #(.NUM_RES(NR), .RES_W(RW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base), .res_in(res),
    .avm_address(addr), .avm_write(wr), .avm_writedata(wdata),
    .avm_waitrequest(wreq), .busy(busy), .done(done)
  );

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } xfer_t;
  typedef struct {
    logic [AW-1:0] base; int pat; int stall_at; int stall_len;
    bit mutate; bit poke; int exp_done;
  } vec_t;

  xfer_t exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference: one write per result at base+i, then optional modular-sum word.
  task automatic build_exp(input logic [AW-1:0] b, input logic [RW-1:0] r [NR]);
    longint unsigned s = 0;
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      exp_q.push_back('{AW'(b + AW'(i)), DW'(r[i])});
      s += r[i];
    end
    if (CHK != 0) exp_q.push_back('{AW'(b + AW'(NR)), DW'(s % (64'd1 << RW))});
  endtask

  task automatic fill(input int pat, output logic [RW-1:0] r [NR]);
    for (int i = 0; i < NR; i++)
      case (pat)
        0:       r[i] = RW'(i + 1);
        1:       r[i] = '1;
        default: r[i] = RW'($urandom);
      endcase
  endtask

  // Entered and left at #1 after a rising edge; the current cycle is cycle 0.
  task automatic run_txn(input string nm, input logic [AW-1:0] b, input logic [RW-1:0] r [NR],
                         input int stall_at, input int stall_len, input bit mutate,
                         input bit poke, input int exp_done);
    xfer_t got[$];
    int cyc = 0, done_cyc = -1, busy_cnt = 0, nxf = 0, stalls = 0, errs = 0, extra = 0;
    bit prev_stall = 0, stable = 1;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd = '0;
    build_exp(b, r);
    base = b; res = r; start = 1'b1; wreq = 1'b0;
    while (cyc < 300 && done_cyc < 0) begin
      @(posedge clk); #1; cyc++;
      start = 1'b0;
      if (mutate && cyc == 1) foreach (res[i]) res[i] = '1;
      if (poke && cyc == 3) start = 1'b1;
      if (busy) busy_cnt++;
      if (prev_stall && (addr !== pa || wdata !== pd || wr !== 1'b1)) stable = 0;
      wreq = 1'b0;
      if (done) begin
        done_cyc = cyc;
        if (poke) start = 1'b1;
      end else if (wr) begin
        if (nxf == stall_at && stalls < stall_len) begin
          wreq = 1'b1; stalls++;
        end else begin
          got.push_back('{addr, wdata}); nxf++;
        end
      end
      prev_stall = wreq; pa = addr; pd = wdata;
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1; start = 1'b0;
      if (wr || busy || done) extra++;
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i].a !== exp_q[i].a || got[i].d !== exp_q[i].d) begin
        if (errs == 0) $display("  %s: transfer %0d was %h/%h, model %h/%h", nm, i,
                                got[i].a, got[i].d, exp_q[i].a, exp_q[i].d);
        errs++;
      end
    check({nm, ".xfer_count"}, got.size(), exp_q.size());
    check({nm, ".xfer_seq_errs"}, errs, 0);
    check({nm, ".done_cycle"}, done_cyc, exp_done);
    check({nm, ".busy_cycles"}, busy_cnt, exp_done - 1);
    check({nm, ".stall_stable"}, stable, 1);
    check({nm, ".post_idle"}, extra, 0);
  endtask

  initial begin
    vec_t tv[7];
    logic [RW-1:0] r [NR];
    tv[0] = '{32'h0000_0100, 0, -1, 0, 1'b0, 1'b0, 9 + CHK};
    tv[1] = '{32'h0000_0100, 0,  3, 3, 1'b0, 1'b0, 12 + CHK};
    tv[2] = '{32'h0000_0040, 2, -1, 0, 1'b1, 1'b0, 9 + CHK};
    tv[3] = '{32'h0000_0080, 0, -1, 0, 1'b0, 1'b1, 9 + CHK};
    tv[4] = '{32'hFFFF_FFFE, 1, -1, 0, 1'b0, 1'b0, 9 + CHK};
    tv[5] = '{32'h0000_1000, 2,  0, 2, 1'b0, 1'b0, 11 + CHK};
    tv[6] = '{32'h0000_2000, 2,  7, 1, 1'b0, 1'b0, 10 + CHK};

    rst = 1'b1; start = 1'b0; wreq = 1'b0; base = '0;
    foreach (res[i]) res[i] = '0;
    #1;
    check("reset.avm_write", wr, 0);
    check("reset.address", addr, 0);
    check("reset.writedata", wdata, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    foreach (tv[t]) begin
      fill(tv[t].pat, r);
      run_txn($sformatf("vec%0d", t), tv[t].base, r, tv[t].stall_at, tv[t].stall_len,
              tv[t].mutate, tv[t].poke, tv[t].exp_done);
    end

    // Asynchronous reset while write 5 is stalled, then a clean restart.
    fill(0, r);
    base = 32'h0000_0200; res = r; start = 1'b1; wreq = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1; start = 1'b0;
      wreq = (c >= 5);
      if (c == 5) check("rst.stall_addr", addr, 32'h0000_0204);
    end
    #2 rst = 1'b1;
    #1;
    check("rst.avm_write", wr, 0);
    check("rst.busy", busy, 0);
    check("rst.address", addr, 0);
    check("rst.done", done, 0);
    @(posedge clk); #1 rst = 1'b0; wreq = 1'b0;
    @(posedge clk); #1;
    fill(2, r);
    run_txn("after_rst", 32'h0000_0300, r, -1, 0, 1'b0, 1'b0, 9 + CHK);

    for (int n = 0; n < 12; n++) begin
      logic [AW-1:0] b;
      int sa, sl;
      fill(2, r);
      b  = (n % 3 == 0) ? (32'hFFFF_FFFF - AW'($urandom_range(0, 10))) : AW'($urandom);
      sa = $urandom_range(0, NR - 1 + CHK);
      sl = $urandom_range(0, 4);
      run_txn($sformatf("rand%0d", n), b, r, sa, sl, 1'b0, 1'b0, NR + 1 + CHK + sl);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
